// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: captures a parallel pattern on start and shifts it out
// MSB-first, optionally repeating the frame with a one-cycle gap between repetitions.
module serial_pattern_tx #(
    parameter int WIDTH   = 8,
    parameter int NBITS_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   data,
    input  logic [NBITS_W-1:0] nbits,
    input  logic [3:0]         reps,
    output logic               out,
    output logic               valid,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_t;

    localparam logic [NBITS_W-1:0] L_WIDTH = NBITS_W'(WIDTH);
    localparam logic [NBITS_W-1:0] L_ONE   = NBITS_W'(1);

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_shift, w_shift_nxt;
    logic [WIDTH-1:0]   r_data_sh, w_data_sh_nxt;
    logic [NBITS_W-1:0] r_cnt, w_cnt_nxt;
    logic [NBITS_W-1:0] r_n_sh, w_n_sh_nxt;
    logic [3:0]         r_reps, w_reps_nxt;
    logic [NBITS_W-1:0] w_n_clamp;
    logic [WIDTH-1:0]   w_data_align;
    logic               r_out, r_valid, r_busy, r_done;

    // Pattern is left-aligned so the bit on the wire is always r_shift[WIDTH-1].
    always_comb begin
        w_n_clamp     = (nbits > L_WIDTH) ? L_WIDTH : nbits;
        w_data_align  = data << (L_WIDTH - w_n_clamp);
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_data_sh_nxt = r_data_sh;
        w_cnt_nxt     = r_cnt;
        w_n_sh_nxt    = r_n_sh;
        w_reps_nxt    = r_reps;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_data_sh_nxt = w_data_align;
                    w_shift_nxt   = w_data_align;
                    w_n_sh_nxt    = w_n_clamp;
                    w_cnt_nxt     = w_n_clamp;
                    w_reps_nxt    = reps;
                    w_state_nxt   = (w_n_clamp != '0) ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                if (r_cnt == L_ONE) begin
                    if (r_reps != 4'd0) begin
                        w_reps_nxt  = r_reps - 4'd1;
                        w_state_nxt = S_GAP;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_cnt_nxt   = r_cnt - L_ONE;
                    w_shift_nxt = r_shift << 1;
                end
            end
            S_GAP: begin
                w_shift_nxt = r_data_sh;
                w_cnt_nxt   = r_n_sh;
                w_state_nxt = S_SHIFT;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_data_sh <= '0;
            r_cnt     <= '0;
            r_n_sh    <= '0;
            r_reps    <= '0;
            r_out     <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_data_sh <= w_data_sh_nxt;
            r_cnt     <= w_cnt_nxt;
            r_n_sh    <= w_n_sh_nxt;
            r_reps    <= w_reps_nxt;
            r_out     <= (w_state_nxt == S_SHIFT) & w_shift_nxt[WIDTH-1];
            r_valid   <= (w_state_nxt == S_SHIFT);
            r_busy    <= (w_state_nxt != S_IDLE);
            r_done    <= (w_state_nxt == S_DONE);
        end
    end

    assign out   = r_out;
    assign valid = r_valid;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

Serial bit-stream transmitter that produces the 1-bit-per-clock input stream consumed by the team's serial sequence-recognising FSMs. It captures a parallel pattern on a start strobe and shifts it out MSB-first, optionally repeating the frame with a one-cycle gap between repetitions. It has a busy/done handshake so a test sequencer or host controller can chain frames.

## Interface
- WIDTH, 8, maximum pattern length in bits (≥2)
- NBITS_W, $clog2(WIDTH+1), width of the nbits port
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request to send a frame; sampled only in IDLE
- data  input  WIDTH  pattern; the low nbits bits are sent
- nbits  input  NBITS_W  frame length in bits; 0 = empty frame; values > WIDTH clamp to WIDTH
- reps  input  4  extra repetitions; total frames = reps+1
- out  output  1  serial bit, registered
- valid  output  1  out carries a pattern bit this cycle
- busy  output  1  transmitter is not in IDLE
- done  output  1  single-cycle completion pulse

## Operation
- States: IDLE, SHIFT, GAP, DONE. All outputs are registered and driven from state/shift registers.
- IDLE: out=0, valid=0, busy=0, done=0. If start=1 at an edge, capture data, the clamped nbits (n), and reps into shadow registers. Next state is SHIFT if n>0, otherwise DONE.
- SHIFT: out = current bit, valid=1, busy=1.
  - Bits go out in the order data[n-1], data[n-2] … data[0].
  - A bit counter (NBITS_W wide) counts down from n.
  - After the last bit: if the remaining-reps counter > 0, decrement it and go to GAP. Otherwise go to DONE.
- GAP: exactly one cycle with out=0, valid=0, busy=1. The shift register reloads from the shadow copy. Next state is SHIFT.
- DONE: exactly one cycle with done=1, busy=1, valid=0, out=0. Next state is IDLE.
- Shadow capture: the data/nbits/reps inputs are don't-care outside the IDLE start edge. Changes mid-frame have no effect.
- start while busy: ignored and not queued.
- start held high continuously: frames restart with exactly one IDLE cycle between DONE and the next SHIFT.
- rst=1 at any edge, including mid-frame:
  - next cycle state=IDLE and out=valid=busy=done=0;
  - all counters and shadow registers are cleared;
  - start is ignored while rst=1;
  - rst has priority over start.

## Timing
- Reset values: out=0, valid=0, busy=0, done=0, state IDLE.
- start sampled at edge k → first bit on out with valid=1 during cycle k+1 (1-cycle latency).
- A frame of n bits occupies n consecutive valid cycles with no bubbles.
- Total busy cycles = (reps+1)·n + reps (gaps) + 1 (DONE).
- done asserts in the cycle immediately after the last valid bit. For n=0, done asserts in cycle k+1 with busy=1 for that single cycle.
- Earliest accepted re-start: the edge at the end of the first IDLE cycle after DONE.
- nbits=WIDTH exercises the full counter range; the counter must not wrap or emit extra bits.

## Test plan
- Basic frame: WIDTH=8, data=8'hB4, nbits=8, reps=0, pulse start → out/valid = 1,0,1,1,0,1,0,0 on 8 consecutive cycles, then done=1 for 1 cycle; busy high 9 cycles; then all outputs 0.
- Short frame with repeats: data=8'h05, nbits=3, reps=2 → valid pattern 1,1,1,0,1,1,1,0,1,1,1 with out=1,0,1 in each frame and 0 in gaps; done one cycle after the 11th cycle; busy=12 cycles.
- Handshake robustness: start pulsed and data changed to 8'hFF at cycle 3 of the 8'hB4 frame → transmitted stream is unchanged and no second frame follows. With start held high → second frame begins exactly 2 cycles after the last bit of the first frame (DONE, IDLE).
- Boundaries:
  - nbits=0 → done at k+1, valid never asserted, busy high for 1 cycle.
  - nbits=12 with WIDTH=8, data=8'h81 → 8 bits 1,0,0,0,0,0,0,1.
- Reset mid-operation: rst=1 during bit 4 of a reps=3 frame → next cycle out=valid=busy=done=0. start held high during rst is ignored. A fresh start after rst deasserts sends a complete correct frame.
- Random regression: 1000 random data/nbits/reps/start sequences, checked against a reference model of the bit order, gap placement, done timing and busy count.
